// File: rtl/fir_mac_engine.sv
// fir_mac_engine: time-multiplexed FIR filter built around one signed MAC.
// Samples enter a circular delay line, and one tap per cycle is accumulated.
// Coefficients can be rewritten at runtime while the engine is idle.
// Optional build macro FIR_SATURATE_EN: output narrowing clamps instead of
// wrapping, and o_sat records any clamp until reset.
module fir_mac_engine #(
    parameter int NUM_TAPS   = 8,
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int SHIFT      = 15
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic signed [DATA_WIDTH-1:0]     iv_din,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic signed [DATA_WIDTH-1:0]     ov_dout,
    input  logic                             i_coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0]      iv_coef_addr,
    input  logic signed [COEF_WIDTH-1:0]     iv_coef_data,
    output logic                             o_coef_err,
    output logic                             o_sat
);

    localparam int AW        = $clog2(NUM_TAPS);
    localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + AW;
    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;

    localparam logic [AW-1:0] LAST_TAP  = AW'(NUM_TAPS - 1);
    localparam logic [AW:0]   TAP_LIMIT = (AW + 1)'(NUM_TAPS);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [DATA_WIDTH-1:0] delay_line [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0] coef_bank  [NUM_TAPS];

    logic [AW-1:0]                wp;
    logic [AW-1:0]                tap;
    logic [AW-1:0]                rd_idx;
    logic                         last_tap;
    logic                         accept;
    logic                         addr_ok;

    logic signed [PROD_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic signed [DATA_WIDTH-1:0] narrowed;
    logic signed [DATA_WIDTH-1:0] dout;
    logic                         coef_err;

    assign last_tap = (tap == LAST_TAP);
    assign accept   = (state == IDLE) && i_valid;
    assign addr_ok  = ({1'b0, iv_coef_addr} < TAP_LIMIT);

    // Handshake outputs come from the state register only; reset masks them
    // so nothing is offered or accepted while i_rst is high.
    assign o_ready    = (state == IDLE) && !i_rst;
    assign o_valid    = (state == OUT) && !i_rst;
    assign ov_dout    = dout;
    assign o_coef_err = coef_err;

    // Read index for x[n-k]: newest sample sits at wp, older ones behind it.
    always_comb begin
        if (wp >= tap) begin
            rd_idx = wp - tap;
        end else begin
            rd_idx = AW'({1'b0, wp} + TAP_LIMIT - {1'b0, tap});
        end
    end

    // Single multiply-accumulate: full-precision product, sign-extended.
    always_comb begin
        product = delay_line[rd_idx] * coef_bank[tap];
        acc_sum = acc + ACC_WIDTH'(product);
    end

`ifdef FIR_SATURATE_EN
    localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0]         shifted;
    logic [ACC_WIDTH-DATA_WIDTH:0]       upper;
    logic                                clamp;
    logic                                sat;

    assign shifted = acc_sum >>> SHIFT;
    assign upper   = shifted[ACC_WIDTH-1:DATA_WIDTH-1];
    assign o_sat   = sat;

    // Clamp to the output range whenever the discarded bits are not pure sign.
    always_comb begin
        narrowed = shifted[DATA_WIDTH-1:0];
        clamp    = 1'b0;
        if (!((&upper) || !(|upper))) begin
            clamp    = 1'b1;
            narrowed = shifted[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX;
        end
    end

    // Sticky overflow flag, raised when a clamped result is produced.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sat <= 1'b0;
        end else if ((state == MAC) && last_tap && clamp) begin
            sat <= 1'b1;
        end
    end
`else
    assign o_sat = 1'b0;

    // Two's-complement wrap: keep only the low bits of the scaled sum.
    always_comb begin
        narrowed = DATA_WIDTH'(acc_sum >>> SHIFT);
    end
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept -> one cycle per tap -> hold result until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid)  state_next = MAC;
            MAC:     if (last_tap) state_next = OUT;
            OUT:     if (i_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Delay line, pointers, accumulator and registered output value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                delay_line[i] <= '0;
            end
            wp   <= '0;
            tap  <= '0;
            acc  <= '0;
            dout <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        delay_line[wp] <= iv_din;
                        acc            <= '0;
                        tap            <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    if (last_tap) begin
                        tap  <= '0;
                        wp   <= (wp == LAST_TAP) ? '0 : wp + AW'(1);
                        dout <= narrowed;
                    end else begin
                        tap <= tap + AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Coefficient bank: writes land only while idle; anything else is flagged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                coef_bank[i] <= '0;
            end
            coef_err <= 1'b0;
        end else begin
            coef_err <= i_coef_we && ((state != IDLE) || !addr_ok);
            if (i_coef_we && (state == IDLE) && addr_ok) begin
                coef_bank[iv_coef_addr] <= iv_coef_data;
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: directed bench for fir_mac_engine with a sum-of-products
// reference model and literal expectations for each scenario.
`timescale 1ns/1ps
module tb_fir_mac_engine;

    localparam int NUM_TAPS   = 4;
    localparam int DATA_WIDTH = 16;
    localparam int COEF_WIDTH = 16;
    localparam int SHIFT      = 0;
    localparam int AW         = 2;
    localparam int LATENCY    = NUM_TAPS + 1;

    typedef struct {
        int value;
        bit sat;
        int cyc;
    } expect_t;

    logic                          clk = 1'b0;
    logic                          i_rst;
    logic                          i_valid;
    logic                          o_ready;
    logic signed [DATA_WIDTH-1:0]  iv_din;
    logic                          o_valid;
    logic                          i_ready;
    logic signed [DATA_WIDTH-1:0]  ov_dout;
    logic                          i_coef_we;
    logic [AW-1:0]                 iv_coef_addr;
    logic signed [COEF_WIDTH-1:0]  iv_coef_data;
    logic                          o_coef_err;
    logic                          o_sat;

    expect_t exp_q[$];
    int      got_q[$];
    int      model_coef [NUM_TAPS];
    int      model_hist [NUM_TAPS];
    bit      model_sat;
    int      pass_count  = 0;
    int      check_count = 0;
    int      cyc         = 0;
    logic    prev_valid  = 1'b0;

    fir_mac_engine #(
        .NUM_TAPS   (NUM_TAPS),
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .SHIFT      (SHIFT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .iv_din       (iv_din),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .ov_dout      (ov_dout),
        .i_coef_we    (i_coef_we),
        .iv_coef_addr (iv_coef_addr),
        .iv_coef_data (iv_coef_data),
        .o_coef_err   (o_coef_err),
        .o_sat        (o_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int gotAt(input int i);
        if (i < got_q.size()) return got_q[i];
        return -999999;
    endfunction

    task automatic modelClear();
        for (int k = 0; k < NUM_TAPS; k++) begin
            model_hist[k] = 0;
            model_coef[k] = 0;
        end
        model_sat = 1'b0;
        exp_q.delete();
    endtask

    // Reference: y[n] = narrow((sum_k c[k]*x[n-k]) >>> SHIFT)
    task automatic modelAccept(input int din);
        longint  sum = 0;
        longint  shifted;
        int      value;
        expect_t e;
        for (int k = NUM_TAPS - 1; k > 0; k--) model_hist[k] = model_hist[k-1];
        model_hist[0] = din;
        for (int k = 0; k < NUM_TAPS; k++) begin
            sum += longint'(model_coef[k]) * longint'(model_hist[k]);
        end
        shifted = sum >>> SHIFT;
`ifdef FIR_SATURATE_EN
        if (shifted > 32767) begin
            value = 32767;
            model_sat = 1'b1;
        end else if (shifted < -32768) begin
            value = -32768;
            model_sat = 1'b1;
        end else begin
            value = int'(shifted);
        end
`else
        begin
            logic [DATA_WIDTH-1:0] low;
            low   = shifted[DATA_WIDTH-1:0];
            value = int'($signed(low));
        end
`endif
        e.value = value;
        e.sat   = model_sat;
        e.cyc   = cyc;
        exp_q.push_back(e);
    endtask

    // Compare process: latency at o_valid rise, value/flag every valid cycle.
    always begin
        @(negedge clk);
        #1;
        if (!i_rst) begin
            if (o_valid && !prev_valid) begin
                if (exp_q.size() == 0) checkOutput("unexpected_valid", 1, 0);
                else checkOutput("latency", cyc - exp_q[0].cyc, LATENCY);
            end
            if (o_valid && exp_q.size() != 0) begin
                checkOutput("dout_model", int'(ov_dout), exp_q[0].value);
                checkOutput("sat_model", int'(o_sat), int'(exp_q[0].sat));
                if (i_ready) begin
                    got_q.push_back(int'(ov_dout));
                    exp_q.delete(0);
                end
            end
        end
        prev_valid <= o_valid && !i_rst;
    end

    task automatic resetDut();
        i_rst = 1'b1;
        modelClear();
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_ready", int'(o_ready), 0);
        checkOutput("reset_valid", int'(o_valid), 0);
        checkOutput("reset_dout", int'(ov_dout), 0);
        checkOutput("reset_coef_err", int'(o_coef_err), 0);
        checkOutput("reset_sat", int'(o_sat), 0);
        i_rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", int'(o_ready), 1);
    endtask

    task automatic applyStimulus(input int din);
        int guard = 0;
        while (!o_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!o_ready) begin
            checkOutput("ready_timeout", 0, 1);
            return;
        end
        i_valid = 1'b1;
        iv_din  = DATA_WIDTH'(din);
        modelAccept(din);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic writeCoef(input int addr, input int data, input int exp_err);
        i_coef_we    = 1'b1;
        iv_coef_addr = AW'(addr);
        iv_coef_data = COEF_WIDTH'(data);
        if (exp_err == 0) model_coef[addr] = data;
        @(negedge clk);
        i_coef_we = 1'b0;
        checkOutput("coef_err_pulse", int'(o_coef_err), exp_err);
        @(negedge clk);
        checkOutput("coef_err_clear", int'(o_coef_err), 0);
    endtask

    task automatic waitReady();
        int guard = 0;
        while (!o_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!o_ready) checkOutput("idle_timeout", 0, 1);
    endtask

    task automatic loadCoefs(input int c0, input int c1, input int c2, input int c3);
        waitReady();
        writeCoef(0, c0, 0);
        writeCoef(1, c1, 0);
        writeCoef(2, c2, 0);
        writeCoef(3, c3, 0);
    endtask

    task automatic drainOutputs();
        int guard = 0;
        while (!(exp_q.size() == 0 && o_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) checkOutput("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int imp_exp [5];
        int sat_exp;
        int held;
        bit seen;
        int guard;

        i_rst        = 1'b1;
        i_valid      = 1'b0;
        iv_din       = '0;
        i_ready      = 1'b1;
        i_coef_we    = 1'b0;
        iv_coef_addr = '0;
        iv_coef_data = '0;
        @(negedge clk);
        resetDut();

        // Impulse response
        loadCoefs(1, 2, 3, 4);
        got_q.delete();
        applyStimulus(1);
        for (int i = 0; i < 4; i++) applyStimulus(0);
        drainOutputs();
        imp_exp = '{1, 2, 3, 4, 0};
        for (int i = 0; i < 5; i++) checkOutput($sformatf("impulse_%0d", i), gotAt(i), imp_exp[i]);

        // Full-scale inputs and coefficients
        loadCoefs(32767, 32767, 32767, 32767);
        got_q.delete();
        for (int i = 0; i < 4; i++) applyStimulus(32767);
        drainOutputs();
        for (int i = 0; i < 4; i++) begin
`ifdef FIR_SATURATE_EN
            sat_exp = 32767;
`else
            sat_exp = i + 1;
`endif
            checkOutput($sformatf("fullscale_%0d", i), gotAt(i), sat_exp);
        end
`ifdef FIR_SATURATE_EN
        checkOutput("sat_sticky", int'(o_sat), 1);
`else
        checkOutput("sat_sticky", int'(o_sat), 0);
`endif

        // Coefficient write while busy is rejected
        loadCoefs(1, 2, 3, 4);
        for (int i = 0; i < 4; i++) applyStimulus(0);
        drainOutputs();
        got_q.delete();
        applyStimulus(1);
        writeCoef(0, 9, 1);
        drainOutputs();
        checkOutput("busy_write_coef0_kept", gotAt(0), 1);
        waitReady();
        writeCoef(3, 8, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0);
        drainOutputs();
        checkOutput("idle_write_tap1", gotAt(1), 2);
        checkOutput("idle_write_tap2", gotAt(2), 3);
        checkOutput("idle_write_tap3", gotAt(3), 8);

        // Backpressure hold
        got_q.delete();
        applyStimulus(3);
        i_ready = 1'b0;
        guard = 0;
        while (!o_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        held = int'(ov_dout);
        checkOutput("bp_value", held, 3);
        i_valid = 1'b1;
        iv_din  = 16'sd100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_valid_held", int'(o_valid), 1);
            checkOutput("bp_dout_held", int'(ov_dout), held);
            checkOutput("bp_ready_low", int'(o_ready), 0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_valid_released", int'(o_valid), 0);
        checkOutput("bp_ready_back", int'(o_ready), 1);
        checkOutput("bp_one_transfer", got_q.size(), 1);

        // Write pointer wrap across many samples
        loadCoefs(1, 2, 3, 4);
        for (int i = 0; i < 3; i++) applyStimulus(0);
        drainOutputs();
        got_q.delete();
        for (int n = 0; n < 9; n++) begin
            applyStimulus(1);
            for (int i = 0; i < 3; i++) applyStimulus(0);
        end
        drainOutputs();
        for (int n = 0; n < 9; n++) checkOutput($sformatf("wrap_impulse_%0d", n), gotAt(4 * n), 1);

        // Reset in the middle of a MAC pass
        applyStimulus(7);
        @(negedge clk);
        resetDut();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        checkOutput("abort_no_valid", int'(seen), 0);
        loadCoefs(1, 0, 0, 0);
        got_q.delete();
        applyStimulus(5);
        drainOutputs();
        checkOutput("after_abort_sample", gotAt(0), 5);
        loadCoefs(0, 1, 1, 1);
        applyStimulus(0);
        drainOutputs();
        checkOutput("after_abort_history", gotAt(1), 5);

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
